// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer.
//   state_e             fetch FSM states
//   DEFAULT_ADDR_WIDTH  default program counter / memory address width
//   IR_LSB / IR_MSB     values driven on IRLH to select the IR byte lane
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      WR_LO = 3'd2,
      WR_HI = 3'd3,
      HOLD  = 3'd4
   } state_e;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 16;

   localparam logic IR_LSB = 1'b0;
   localparam logic IR_MSB = 1'b1;

endpackage : fetch_pkg

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Loadable, incrementing program counter that wraps modulo 2^ADDR_WIDTH.
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   synchronous active-high reset, loads RESET_PC
//   Inc        in   advance PC by one byte
//   Load       in   load LoadValue (wins over Inc)
//   LoadValue  in   redirect target
//   PCOut      out  current PC
// -----------------------------------------------------------------------------
module program_counter
   import fetch_pkg::*;
#(
   parameter int unsigned             ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Inc,
   input  logic                  Load,
   input  logic [ADDR_WIDTH-1:0] LoadValue,
   output logic [ADDR_WIDTH-1:0] PCOut
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   // Natural overflow of the adder gives the required wrap-around.
   always_comb begin
      pc_d = pc_q;
      if (Load) begin
         pc_d = LoadValue;
      end else if (Inc) begin
         pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign PCOut = pc_q;

endmodule : program_counter

// File: rtl/instruction_fetch_controller.sv
// -----------------------------------------------------------------------------
// instruction_fetch_controller
// Fetch sequencer sitting in front of a 16-bit instruction register built from
// two byte lanes. Reads the LSB at PC and the MSB at PC+1 from a synchronous
// 8-bit instruction memory, steers each returned byte into the IR, then offers
// the complete instruction to the decoder with a valid/ready handshake.
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   synchronous active-high reset
//   Run          in   1 = keep fetching, 0 = stop at next instruction boundary
//   MemAddr      out  instruction memory byte address (always the PC)
//   MemRead      out  read strobe, data appears on MemData next cycle
//   MemData      in   memory read data (goes straight to the IR, unused here)
//   IRWrite      out  IR byte write enable
//   IRLH         out  IR byte select, 0 = LSB, 1 = MSB
//   InstrValid   out  IR holds a complete instruction fetched from InstrPC
//   InstrReady   in   decoder accepts when InstrValid & InstrReady
//   InstrPC      out  address of the LSB of the instruction in the IR
//   PCLoad       in   redirect request
//   PCLoadValue  in   redirect target
//   PCOut        out  current PC (next byte to fetch)
// -----------------------------------------------------------------------------
module instruction_fetch_controller
   import fetch_pkg::*;
#(
   parameter int unsigned             ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Run,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic                  MemRead,
   input  logic [7:0]            MemData,
   output logic                  IRWrite,
   output logic                  IRLH,
   output logic                  InstrValid,
   input  logic                  InstrReady,
   output logic [ADDR_WIDTH-1:0] InstrPC,
   input  logic                  PCLoad,
   input  logic [ADDR_WIDTH-1:0] PCLoadValue,
   output logic [ADDR_WIDTH-1:0] PCOut
);

   state_e                state_q;
   state_e                state_d;
   logic [ADDR_WIDTH-1:0] instr_pc_q;
   logic [ADDR_WIDTH-1:0] instr_pc_d;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  pc_inc;
   logic                  pc_load;
   logic                  mem_data_unused;

   // The IR takes MemData directly; the sequencer never looks at it.
   assign mem_data_unused = ^MemData;

   program_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc (
      .Clock     (Clock),
      .Reset     (Reset),
      .Inc       (pc_inc),
      .Load      (pc_load),
      .LoadValue (PCLoadValue),
      .PCOut     (pc)
   );

   // Next state, PC control and InstrPC capture.
   always_comb begin
      state_d    = state_q;
      instr_pc_d = instr_pc_q;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            pc_load = PCLoad;
            if (Run) begin
               state_d = RD_LO;
            end
         end
         RD_LO: begin
            instr_pc_d = pc;
            pc_inc     = 1'b1;
            state_d    = WR_LO;
         end
         WR_LO: begin
            // MSB read overlaps the LSB write.
            pc_inc  = 1'b1;
            state_d = WR_HI;
         end
         WR_HI: begin
            state_d = HOLD;
         end
         HOLD: begin
            // Redirects and Run changes only take effect on acceptance.
            if (InstrReady) begin
               pc_load = PCLoad;
               state_d = Run ? RD_LO : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobe decode. Read/write strobes are suppressed in a reset cycle so a
   // reset landing mid-fetch cannot overwrite the IR with a partial byte.
   always_comb begin
      MemAddr    = pc;
      MemRead    = 1'b0;
      IRWrite    = 1'b0;
      IRLH       = IR_LSB;
      InstrValid = 1'b0;
      unique case (state_q)
         RD_LO: begin
            MemRead = ~Reset;
         end
         WR_LO: begin
            MemRead = ~Reset;
            IRWrite = ~Reset;
            IRLH    = IR_LSB;
         end
         WR_HI: begin
            IRWrite = ~Reset;
            IRLH    = IR_MSB;
         end
         HOLD: begin
            InstrValid = 1'b1;
         end
         default: begin
            MemRead = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= IDLE;
         instr_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   assign InstrPC = instr_pc_q;
   assign PCOut   = pc;

endmodule : instruction_fetch_controller

// File: tb/tb_instruction_fetch_controller.sv
module tb_instruction_fetch_controller;

   typedef struct {
      logic        rst;
      logic        run;
      logic        rdy;
      logic        ld;
      logic [15:0] ldv;
      logic        chk;
      logic        rd;
      logic        wr;
      logic        lh;
      logic        vld;
      logic [15:0] addr;
      logic [15:0] ipc;
      logic [15:0] pc;
      logic        chk_ir;
      logic [15:0] ir;
   } vec_t;

   vec_t vecs[$];

   int tests  = 0;
   int failed = 0;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- DUT 0 : RESET_PC = 0 ----------------
   logic        Reset0 = 1'b1, Run0 = 1'b0, Ready0 = 1'b0, PCLoad0 = 1'b0;
   logic [15:0] PCLoadValue0 = 16'h0;
   logic [15:0] MemAddr0, InstrPC0, PCOut0;
   logic        MemRead0, IRWrite0, IRLH0, InstrValid0;
   logic [7:0]  MemData0 = 8'h0;
   logic [15:0] ir0 = 16'h0;
   logic [7:0]  mem0 [0:65535];

   instruction_fetch_controller #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut0 (
      .Clock(Clock), .Reset(Reset0), .Run(Run0),
      .MemAddr(MemAddr0), .MemRead(MemRead0), .MemData(MemData0),
      .IRWrite(IRWrite0), .IRLH(IRLH0), .InstrValid(InstrValid0),
      .InstrReady(Ready0), .InstrPC(InstrPC0),
      .PCLoad(PCLoad0), .PCLoadValue(PCLoadValue0), .PCOut(PCOut0)
   );

   always @(posedge Clock) begin
      if (MemRead0) MemData0 <= mem0[MemAddr0];
      if (IRWrite0) begin
         if (IRLH0) ir0[15:8] <= MemData0;
         else       ir0[7:0]  <= MemData0;
      end
   end

   // ---------------- DUT 1 : RESET_PC = FFFF ----------------
   logic        Reset1 = 1'b1, Run1 = 1'b0, Ready1 = 1'b1, PCLoad1 = 1'b0;
   logic [15:0] PCLoadValue1 = 16'h0;
   logic [15:0] MemAddr1, InstrPC1, PCOut1;
   logic        MemRead1, IRWrite1, IRLH1, InstrValid1;
   logic [7:0]  MemData1 = 8'h0;
   logic [15:0] ir1 = 16'h0;
   logic [7:0]  mem1 [0:65535];

   instruction_fetch_controller #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFF)) dut1 (
      .Clock(Clock), .Reset(Reset1), .Run(Run1),
      .MemAddr(MemAddr1), .MemRead(MemRead1), .MemData(MemData1),
      .IRWrite(IRWrite1), .IRLH(IRLH1), .InstrValid(InstrValid1),
      .InstrReady(Ready1), .InstrPC(InstrPC1),
      .PCLoad(PCLoad1), .PCLoadValue(PCLoadValue1), .PCOut(PCOut1)
   );

   always @(posedge Clock) begin
      if (MemRead1) MemData1 <= mem1[MemAddr1];
      if (IRWrite1) begin
         if (IRLH1) ir1[15:8] <= MemData1;
         else       ir1[7:0]  <= MemData1;
      end
   end

   // The IR must never be written while it is being offered to the decoder.
   always @(negedge Clock) begin
      if (IRWrite0 && InstrValid0) begin
         failed++;
         $display("FAIL irwrite_vs_valid dut0 at %0t: IRWrite=1 InstrValid=1, required not both", $time);
      end
      if (IRWrite1 && InstrValid1) begin
         failed++;
         $display("FAIL irwrite_vs_valid dut1 at %0t: IRWrite=1 InstrValid=1, required not both", $time);
      end
   end

   task automatic add(input logic rst, run, rdy, ld, input logic [15:0] ldv,
                      input logic chk, rd, wr, lh, vld,
                      input logic [15:0] addr, ipc, pc,
                      input logic chk_ir, input logic [15:0] ir);
      vec_t v;
      v.rst = rst; v.run = run; v.rdy = rdy; v.ld = ld; v.ldv = ldv;
      v.chk = chk; v.rd = rd; v.wr = wr; v.lh = lh; v.vld = vld;
      v.addr = addr; v.ipc = ipc; v.pc = pc; v.chk_ir = chk_ir; v.ir = ir;
      vecs.push_back(v);
   endtask

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   initial begin
      logic [51:0] act_v;
      logic [51:0] exp_v;
      int          k;

      for (int i = 0; i < 65536; i++) begin
         mem0[i] = 8'h00;
         mem1[i] = 8'h00;
      end
      mem0[16'h0000] = 8'h34; mem0[16'h0001] = 8'h12;
      mem0[16'h0002] = 8'h78; mem0[16'h0003] = 8'h56;
      mem0[16'h0040] = 8'hBC; mem0[16'h0041] = 8'h9A;
      mem0[16'h0042] = 8'hEE; mem0[16'h0043] = 8'hDD;
      mem1[16'hFFFF] = 8'hCD; mem1[16'h0000] = 8'hAB;

      //  rst run rdy ld ldv      chk rd wr lh vld addr     ipc      pc       chkir ir
      add(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
      add(1, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h0001, 16'h0000, 16'h0001, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h0002, 16'h0000, 16'h0002, 0, 16'h0000);
      // HOLD with decoder stalled: redirect and Run changes ignored
      add(0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0002, 16'h0000, 16'h0002, 1, 16'h1234);
      add(0, 1, 0, 1, 16'h0099, 1, 0, 0, 0, 1, 16'h0002, 16'h0000, 16'h0002, 0, 16'h0000);
      add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0002, 16'h0000, 16'h0002, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0002, 16'h0000, 16'h0002, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0002, 16'h0000, 16'h0002, 1, 16'h1234);
      add(0, 1, 1, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0002, 16'h0000, 16'h0002, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0002, 16'h0000, 16'h0002, 0, 16'h0000);
      // redirect during WR_LO is ignored
      add(0, 1, 1, 1, 16'h0070, 1, 1, 1, 0, 0, 16'h0003, 16'h0002, 16'h0003, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h0004, 16'h0002, 16'h0004, 0, 16'h0000);
      // redirect on the accepting HOLD cycle
      add(0, 1, 1, 1, 16'h0040, 1, 0, 0, 0, 1, 16'h0004, 16'h0002, 16'h0004, 1, 16'h5678);
      // Run dropped mid-fetch: completes, then IDLE after acceptance
      add(0, 0, 1, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0040, 16'h0002, 16'h0040, 0, 16'h0000);
      add(0, 0, 1, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h0041, 16'h0040, 16'h0041, 0, 16'h0000);
      add(0, 0, 1, 0, 16'h0000, 1, 0, 1, 1, 0, 16'h0042, 16'h0040, 16'h0042, 0, 16'h0000);
      add(0, 0, 1, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h0042, 16'h0040, 16'h0042, 1, 16'h9ABC);
      add(0, 1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0042, 16'h0040, 16'h0042, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0042, 16'h0040, 16'h0042, 0, 16'h0000);
      // reset during WR_LO: no IR write, back to IDLE at RESET_PC
      add(1, 1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0043, 16'h0042, 16'h0043, 0, 16'h0000);
      add(0, 0, 1, 1, 16'h0010, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h9ABC);
      add(0, 0, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010, 0, 16'h0000);
      add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010, 1, 16'h9ABC);

      for (int r = 0; r < vecs.size(); r++) begin
         @(negedge Clock);
         Reset0       = vecs[r].rst;
         Run0         = vecs[r].run;
         Ready0       = vecs[r].rdy;
         PCLoad0      = vecs[r].ld;
         PCLoadValue0 = vecs[r].ldv;
         #1;
         if (vecs[r].chk) begin
            tests++;
            act_v = {MemRead0, IRWrite0, IRLH0, InstrValid0, MemAddr0, InstrPC0, PCOut0};
            exp_v = {vecs[r].rd, vecs[r].wr, vecs[r].lh, vecs[r].vld,
                     vecs[r].addr, vecs[r].ipc, vecs[r].pc};
            if (act_v !== exp_v) begin
               failed++;
               $display("FAIL row%0d {rd,wr,lh,vld,addr,ipc,pc}: got %b%b%b%b %h %h %h, required %b%b%b%b %h %h %h",
                        r, MemRead0, IRWrite0, IRLH0, InstrValid0, MemAddr0, InstrPC0, PCOut0,
                        vecs[r].rd, vecs[r].wr, vecs[r].lh, vecs[r].vld,
                        vecs[r].addr, vecs[r].ipc, vecs[r].pc);
            end
         end
         if (vecs[r].chk_ir) begin
            check16($sformatf("row%0d_ir", r), ir0, vecs[r].ir);
         end
      end

      // Wrap-around fetch on the RESET_PC = FFFF instance.
      @(negedge Clock);
      Reset1 = 1'b1;
      @(negedge Clock);
      Reset1 = 1'b0;
      #1;
      check16("wrap_reset_pc", PCOut1, 16'hFFFF);
      check16("wrap_reset_addr", MemAddr1, 16'hFFFF);
      @(negedge Clock);
      Run1 = 1'b1;
      k = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge Clock);
         #1;
         if (InstrValid1) begin
            k = c;
            break;
         end
      end
      Run1 = 1'b0;
      check16("wrap_latency", 16'(k), 16'd4);
      check16("wrap_ir", ir1, 16'hABCD);
      check16("wrap_instr_pc", InstrPC1, 16'hFFFF);
      check16("wrap_pc_out", PCOut1, 16'h0001);

      @(negedge Clock);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_instruction_fetch_controller
